// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder with RV32I width decode, byte-lane RAM and fixed wait states
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        in_idle, c_write, bad_op, misaligned, out_of_range, err, enter_resp, we;
    logic [2:0]  c_op;
    logic [31:0] c_addr, c_wdata, rword, load_val, wr_data;
    logic [AW-1:0] c_idx;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [3:0]  be;

    // In IDLE the live request is decoded so a zero-wait-state access can commit on its acceptance edge
    always_comb begin
        in_idle      = (state_q == S_IDLE);
        c_write      = in_idle ? req_write : write_q;
        c_op         = in_idle ? req_op    : op_q;
        c_addr       = in_idle ? req_addr  : addr_q;
        c_wdata      = in_idle ? req_wdata : wdata_q;
        c_idx        = c_addr[AW+1:2];
        rword        = mem[c_idx];
        bad_op       = c_write ? (c_op[2] || c_op[1:0] == 2'b11)
                               : (c_op == 3'b011 || c_op[2:1] == 2'b11);
        misaligned   = (c_op[1:0] == 2'b01 && c_addr[0]) || (c_op[1:0] == 2'b10 && c_addr[1:0] != 2'b00);
        out_of_range = (c_addr[31:AW+2] != '0);
        err          = bad_op || misaligned || out_of_range;
        lbyte        = rword[8*c_addr[1:0] +: 8];
        lhalf        = c_addr[1] ? rword[31:16] : rword[15:0];
        load_val     = (c_op == 3'b000) ? {{24{lbyte[7]}}, lbyte} :
                       (c_op == 3'b001) ? {{16{lhalf[15]}}, lhalf} :
                       (c_op == 3'b100) ? {24'b0, lbyte} :
                       (c_op == 3'b101) ? {16'b0, lhalf} : rword;
        be           = (c_op[1:0] == 2'b00) ? (4'b0001 << c_addr[1:0]) :
                       (c_op[1:0] == 2'b01) ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wr_data      = (c_op[1:0] == 2'b00) ? {4{c_wdata[7:0]}} :
                       (c_op[1:0] == 2'b01) ? {2{c_wdata[15:0]}} : c_wdata;
    end

    // Next-state, wait counter, request capture and response formation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                write_d = req_write;
                op_d    = req_op;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: if (cnt_q == 3'd0) state_d = S_RESP;
                    else cnt_d = cnt_q - 3'd1;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        if (enter_resp) begin
            rdata_d = (!c_write && !err) ? load_val : 32'd0;
            error_d = err;
        end
        we = enter_resp && c_write && !err && reset_n;
    end

    // Control and response registers; reset abandons any pending access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            write_q <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Byte-lane-masked RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;
endmodule
